// File: rtl/y86_pkg.sv
// Shared Y86 constants for the instruction prefetcher: icodes,
// prefetch state encoding and the instruction-window width.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam int unsigned IWIN_W = 80;

  typedef enum logic [1:0] {
    PF_FIRST,
    PF_REST,
    PF_HOLD,
    PF_STOP
  } pf_state_e;

endpackage

// File: rtl/instr_len_decode.sv
// Y86 instruction length from icode; icodes above IPOPQ
// decode as 1-byte invalid instructions.
module instr_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       invalid_o
);

  always_comb begin
    len_o     = 4'd1;
    invalid_o = 1'b0;
    case (icode_i)
      IHALT, INOP, IRET:                len_o = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:     len_o = 4'd2;
      IJXX, ICALL:                      len_o = 4'd9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:        len_o = 4'd10;
      default:                          invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_prefetch.sv
// Byte-serial Y86 instruction prefetcher with redirect support.
// Define PREFETCH_HALT_STOP_EN to idle after halt/invalid/error.
module instr_prefetch
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [63:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_err,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_pc,
  output logic [IWIN_W-1:0] out_bytes,
  output logic [3:0]        out_len,
  output logic              out_err,
  output logic              out_invalid
);

  pf_state_e         state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       rpc_q, rpc_d;
  logic [63:0]       pc_q, pc_d;
  logic [IWIN_W-1:0] bytes_q, bytes_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q, len_d;
  logic              err_q, err_d;
  logic              inv_q, inv_d;
  logic              drain_q, drain_d;

  logic       ack;
  logic       hs;
  logic       halt;
  logic [7:0] byte_in;
  logic [3:0] dec_len;
  logic       dec_inv;

  assign byte_in = mem_err ? 8'h00 : mem_rdata;

  instr_len_decode u_dec (
    .icode_i   (byte_in[7:4]),
    .len_o     (dec_len),
    .invalid_o (dec_inv)
  );

  assign mem_req = ~rst & (drain_q | (state_q == PF_FIRST)
                                   | (state_q == PF_REST));
  assign mem_addr    = addr_q;
  assign ack         = mem_req & mem_ack;
  assign out_valid   = (state_q == PF_HOLD) & ~drain_q;
  assign hs          = out_valid & out_ready;
  assign out_pc      = pc_q;
  assign out_bytes   = bytes_q;
  assign out_len     = len_q;
  assign out_err     = err_q;
  assign out_invalid = inv_q;

`ifdef PREFETCH_HALT_STOP_EN
  assign halt = (bytes_q[7:4] == IHALT) | inv_q | err_q;
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rpc_d   = rpc_q;
    pc_d    = pc_q;
    bytes_d = bytes_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    inv_d   = inv_q;
    drain_d = drain_q;
    if (drain_q) begin
      // data returned for an abandoned request is dropped
      if (ack) begin
        drain_d = 1'b0;
        state_d = PF_FIRST;
        addr_d  = rpc_q;
      end
    end else begin
      unique case (state_q)
        PF_FIRST: if (ack) begin
          pc_d    = addr_q;
          bytes_d = {{(IWIN_W-8){1'b0}}, byte_in};
          cnt_d   = 4'd1;
          addr_d  = addr_q + 64'd1;
          err_d   = mem_err;
          inv_d   = dec_inv;
          len_d   = dec_len;
          state_d = (mem_err || dec_len == 4'd1) ? PF_HOLD : PF_REST;
        end
        PF_REST: if (ack) begin
          for (int k = 1; k < 10; k++)
            if (cnt_q == 4'(k)) bytes_d[8*k +: 8] = byte_in;
          cnt_d  = cnt_q + 4'd1;
          addr_d = addr_q + 64'd1;
          if (mem_err) begin
            err_d   = 1'b1;
            len_d   = cnt_q + 4'd1;
            state_d = PF_HOLD;
          end else if (cnt_q + 4'd1 == len_q) begin
            state_d = PF_HOLD;
          end
        end
        PF_HOLD: if (hs) begin
          addr_d  = pc_q + 64'(len_q);
          state_d = halt ? PF_STOP : PF_FIRST;
        end
        PF_STOP: ;
        default: ;
      endcase
    end
    if (redirect_valid) begin
      state_d = PF_FIRST;
      if (mem_req & ~mem_ack) begin
        drain_d = 1'b1;
        rpc_d   = redirect_pc;
        addr_d  = addr_q;
      end else begin
        drain_d = 1'b0;
        addr_d  = redirect_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PF_FIRST;
      addr_q  <= RESET_PC;
      rpc_q   <= '0;
      pc_q    <= '0;
      bytes_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rpc_q   <= rpc_d;
      pc_q    <= pc_d;
      bytes_q <= bytes_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      inv_q   <= inv_d;
      drain_q <= drain_d;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch against a byte memory model
// with programmable ack latency and per-address error flags.
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [79:0] out_bytes;
  logic [3:0]  out_len;
  logic        out_err;
  logic        out_invalid;

  logic [7:0] mem [0:255];
  logic       merr [0:255];
  int         lat;
  int         wcnt;
  int         nvec;
  int         nmis;

  instr_prefetch #(.RESET_PC(64'd0)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_bytes      (out_bytes),
    .out_len        (out_len),
    .out_err        (out_err),
    .out_invalid    (out_invalid)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_ack   = mem_req && (wcnt >= lat);
    mem_rdata = mem_ack ? mem[mem_addr[7:0]] : 8'h00;
    mem_err   = mem_ack && merr[mem_addr[7:0]];
  end

  always @(posedge clk)
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;

  task automatic check(input string tag,
                       input logic [79:0] obs,
                       input logic [79:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid", out_valid, 1'b1);
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    int saw;
    nvec = 0;
    nmis = 0;
    lat  = 0;
    wcnt = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      merr[i] = 1'b0;
    end
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'h10;
    mem[8'h06] = 8'h30; mem[8'h07] = 8'hF2;
    mem[8'h08] = 8'hCD; mem[8'h09] = 8'hAB;
    mem[8'h30] = 8'h60; mem[8'h31] = 8'h12;
    mem[8'h32] = 8'h10;
    mem[8'h40] = 8'h10;
    mem[8'h50] = 8'h70;
    for (int i = 1; i < 9; i++) mem[8'h50 + i] = 8'(8'hA0 + i);
    mem[8'h60] = 8'h40; mem[8'h61] = 8'h02; mem[8'h62] = 8'h55;
    merr[8'h62] = 1'b1;
    mem[8'h70] = 8'hC5;
    mem[8'h80] = 8'h10;
    mem[8'hFF] = 8'h20;

    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_bytes", out_bytes, 80'd0);
    check("rst_len", out_len, 4'd0);
    check("rst_err", out_err, 1'b0);
    check("rst_inv", out_invalid, 1'b0);
    rst = 1'b0;
    #1;
    check("first_req", mem_req, 1'b1);
    check("first_addr", mem_addr, 64'd0);

    @(negedge clk);
    check("b1_valid", out_valid, 1'b1);
    check("b1_bytes", out_bytes, 80'h10);
    check("b1_len", out_len, 4'd1);
    check("b1_hold_req", mem_req, 1'b0);
    @(negedge clk);
    check("b1_next", mem_addr, 64'd1);
    out_ready = 1'b0;
    @(negedge clk);

    redirect_to(64'd6);
    wait_valid(200, n);
    check("b10_cycles", n, 10);
    check("b10_pc", out_pc, 64'd6);
    check("b10_len", out_len, 4'd10);
    check("b10_bytes", out_bytes, 80'h0000_0000_0000_ABCD_F230);
    check("b10_inv", out_invalid, 1'b0);
    handshake();
    check("b10_next", mem_addr, 64'd16);
    @(negedge clk);

    lat = 2;
    redirect_to(64'h30);
    wait_valid(200, n);
    check("slow_cycles", n, 6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_req", mem_req, 1'b0);
      check("stall_bytes", out_bytes, 80'h1260);
      check("stall_pc", out_pc, 64'h30);
    end
    handshake();
    check("stall_next_req", mem_req, 1'b1);
    check("stall_next", mem_addr, 64'h32);

    redirect_to(64'h50);
    n = 0;
    while (!(mem_req && mem_addr == 64'h54 && !mem_ack) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("jxx_byte4", mem_addr, 64'h54);
    redirect_to(64'h48);
    redirect_to(64'h40);
    bad = 0;
    saw = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_addr == 64'h40) break;
      if (out_valid) saw = 1;
      if (mem_addr != 64'h54) bad++;
      @(negedge clk);
    end
    check("redir_addr", mem_addr, 64'h40);
    check("redir_novalid", saw, 0);
    check("redir_held", bad, 0);
    wait_valid(50, n);
    check("redir_pc", out_pc, 64'h40);
    check("redir_bytes", out_bytes, 80'h10);
    lat = 0;

    redirect_to(64'h60);
    wait_valid(50, n);
    check("err_flag", out_err, 1'b1);
    check("err_len", out_len, 4'd3);
    check("err_bytes", out_bytes, 80'h0240);
    check("err_pc", out_pc, 64'h60);

    redirect_to(64'h70);
    wait_valid(50, n);
    check("inv_flag", out_invalid, 1'b1);
    check("inv_len", out_len, 4'd1);
    check("inv_err", out_err, 1'b0);

    redirect_to(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(50, n);
    check("wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_bytes", out_bytes, 80'h1020);
    check("wrap_len", out_len, 4'd2);
    handshake();
    check("wrap_next", mem_addr, 64'd1);
    @(negedge clk);

    out_ready = 1'b1;
    redirect_to(64'h80);
    out_ready = 1'b0;
    check("hsredir_valid", out_valid, 1'b0);
    check("hsredir_addr", mem_addr, 64'h80);
    @(negedge clk);

    redirect_to(64'h10);
    wait_valid(50, n);
    check("halt_bytes", out_bytes, 80'h0);
    check("halt_len", out_len, 4'd1);
    handshake();
`ifdef PREFETCH_HALT_STOP_EN
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req || out_valid) bad++;
      @(negedge clk);
    end
    check("stop_idle", bad, 0);
    redirect_to(64'h20);
    check("stop_wake_req", mem_req, 1'b1);
    check("stop_wake_addr", mem_addr, 64'h20);
`else
    check("halt_next_req", mem_req, 1'b1);
    check("halt_next", mem_addr, 64'h11);
`endif

    lat = 2;
    redirect_to(64'h90);
    rst = 1'b1;
    #1;
    check("midrst_req", mem_req, 1'b0);
    check("midrst_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_req", mem_req, 1'b1);
    check("postrst_addr", mem_addr, 64'd0);
    wait_valid(50, n);
    check("postrst_bytes", out_bytes, 80'h10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
